// File: rtl/d_route_ctrl.sv
// Routes words popped from a virtual-channel FIFO into the D0/D1 destination FIFOs.
// Credit counters track downstream occupancy so pops never overrun either destination.
module d_route_ctrl #(
    parameter int unsigned data_width    = 6,
    parameter int unsigned address_width = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [3:0]            umbral_D0_in,
    input  logic [3:0]            umbral_D1_in,
    input  logic                  vc_empty,
    input  logic [data_width-1:0] vc_data,
    input  logic                  d0_rd_enable,
    input  logic                  d1_rd_enable,
    output logic                  vc_rd_enable,
    output logic                  d0_wr_enable,
    output logic                  d1_wr_enable,
    output logic [data_width-1:0] d_data_out,
    output logic                  idle_out,
    output logic                  error_out
);

    localparam int unsigned Depth = 1 << address_width;
    localparam int unsigned OccW  = address_width + 1;
    localparam logic [OccW-1:0] DepthOcc = OccW'(Depth);
    localparam logic [3:0]      DepthUmb = 4'(Depth);

    typedef enum logic [2:0] {
        StReset,
        StInit,
        StIdle,
        StActive,
        StError
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [OccW-1:0]       r_thr_d0;
    logic [OccW-1:0]       r_thr_d1;
    logic [OccW-1:0]       r_occ_d0;
    logic [OccW-1:0]       r_occ_d1;
    logic [1:0]            r_pending;
    logic                  r_rd_q;
    logic                  r_d0_wr;
    logic                  r_d1_wr;
    logic [data_width-1:0] r_data;

    logic                  w_err;
    logic                  w_flush;
    logic                  w_room_d0;
    logic                  w_room_d1;
    logic                  w_pop;
    logic                  w_write;
    logic                  w_dest;

    function automatic logic [OccW-1:0] clamp_thr(input logic [3:0] umb);
        if (umb == 4'd0) begin
            return OccW'(1);
        end else if (umb > DepthUmb) begin
            return DepthOcc;
        end else begin
            return umb[OccW-1:0];
        end
    endfunction

    assign w_err = (d0_rd_enable && (r_occ_d0 == '0))
                 | (d1_rd_enable && (r_occ_d1 == '0))
                 | (r_d0_wr && (r_occ_d0 == DepthOcc))
                 | (r_d1_wr && (r_occ_d1 == DepthOcc));

    assign w_flush = w_err | (r_state == StError);

    // Words still in flight count against both destinations: their target is not yet known.
    assign w_room_d0 = ({1'b0, r_occ_d0} + {{(OccW-1){1'b0}}, r_pending}) < {1'b0, r_thr_d0};
    assign w_room_d1 = ({1'b0, r_occ_d1} + {{(OccW-1){1'b0}}, r_pending}) < {1'b0, r_thr_d1};

    assign w_pop = ((r_state == StIdle) || (r_state == StActive)) && !init && !vc_empty
                && w_room_d0 && w_room_d1 && !w_err;

    assign w_write = r_d0_wr | r_d1_wr;
    assign w_dest  = vc_data[data_width-2];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StReset: begin
                if (init) w_state_next = StInit;
            end
            StInit: begin
                if (!init) w_state_next = StIdle;
            end
            StIdle: begin
                if (init) begin
                    w_state_next = StInit;
                end else if (w_pop) begin
                    w_state_next = StActive;
                end
            end
            StActive: begin
                if (init) begin
                    w_state_next = StInit;
                end else if (vc_empty && (r_pending == 2'd0)) begin
                    w_state_next = StIdle;
                end
            end
            StError: begin
                w_state_next = StError;
            end
            default: begin
                w_state_next = StReset;
            end
        endcase
        if (w_err) w_state_next = StError;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StReset;
            r_thr_d0  <= DepthOcc;
            r_thr_d1  <= DepthOcc;
            r_occ_d0  <= '0;
            r_occ_d1  <= '0;
            r_pending <= '0;
            r_rd_q    <= 1'b0;
            r_d0_wr   <= 1'b0;
            r_d1_wr   <= 1'b0;
            r_data    <= '0;
        end else begin
            r_state <= w_state_next;

            if (r_state == StInit) begin
                r_thr_d0 <= clamp_thr(umbral_D0_in);
                r_thr_d1 <= clamp_thr(umbral_D1_in);
            end

            r_rd_q <= w_pop;

            // vc_data is valid the cycle after the pop; capture it into the write stage.
            if (r_rd_q && !w_flush) begin
                r_d0_wr <= !w_dest;
                r_d1_wr <= w_dest;
                r_data  <= vc_data;
            end else begin
                r_d0_wr <= 1'b0;
                r_d1_wr <= 1'b0;
                r_data  <= '0;
            end

            if (w_flush) begin
                r_pending <= '0;
            end else if (w_pop && !w_write) begin
                r_pending <= r_pending + 2'd1;
            end else if (!w_pop && w_write) begin
                r_pending <= r_pending - 2'd1;
            end

            if (!w_flush) begin
                if (r_d0_wr && !d0_rd_enable) begin
                    r_occ_d0 <= r_occ_d0 + OccW'(1);
                end else if (!r_d0_wr && d0_rd_enable) begin
                    r_occ_d0 <= r_occ_d0 - OccW'(1);
                end
                if (r_d1_wr && !d1_rd_enable) begin
                    r_occ_d1 <= r_occ_d1 + OccW'(1);
                end else if (!r_d1_wr && d1_rd_enable) begin
                    r_occ_d1 <= r_occ_d1 - OccW'(1);
                end
            end
        end
    end

    assign vc_rd_enable = w_pop;
    assign d0_wr_enable = r_d0_wr;
    assign d1_wr_enable = r_d1_wr;
    assign d_data_out   = r_data;
    assign idle_out     = (r_state == StIdle);
    assign error_out    = (r_state == StError);

endmodule

// File: tb/tb_d_route_ctrl.sv
// Directed bench for d_route_ctrl: a behavioural VC FIFO feeds the DUT, a negedge monitor logs
// pops and writes, and each scenario task compares against hand-computed values.
module tb_d_route_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [3:0] umb0;
    logic [3:0] umb1;
    logic       vc_empty;
    logic [5:0] vc_data;
    logic       d0_rd;
    logic       d1_rd;
    logic       vc_rd_enable;
    logic       d0_wr_enable;
    logic       d1_wr_enable;
    logic [5:0] d_data_out;
    logic       idle_out;
    logic       error_out;

    int n_checks = 0;
    int n_errors = 0;

    d_route_ctrl #(
        .data_width   (6),
        .address_width(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .umbral_D0_in(umb0),
        .umbral_D1_in(umb1),
        .vc_empty    (vc_empty),
        .vc_data     (vc_data),
        .d0_rd_enable(d0_rd),
        .d1_rd_enable(d1_rd),
        .vc_rd_enable(vc_rd_enable),
        .d0_wr_enable(d0_wr_enable),
        .d1_wr_enable(d1_wr_enable),
        .d_data_out  (d_data_out),
        .idle_out    (idle_out),
        .error_out   (error_out)
    );

    always #5 clk = ~clk;

    // Source VC FIFO: read data appears the cycle after the pop strobe.
    logic [5:0]  vc_mem [64];
    int unsigned vc_wr = 0;
    int unsigned vc_rd = 0;
    assign vc_empty = (vc_wr == vc_rd);

    always @(posedge clk) begin
        if (vc_rd_enable) begin
            vc_data <= vc_mem[vc_rd[5:0]];
            vc_rd   <= vc_rd + 1;
        end
    end

    int         pop_cnt = 0;
    logic [5:0] log0 [$];
    logic [5:0] log1 [$];

    always @(negedge clk) begin
        if (vc_rd_enable) pop_cnt <= pop_cnt + 1;
        if (d0_wr_enable) log0.push_back(d_data_out);
        if (d1_wr_enable) log1.push_back(d_data_out);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic [5:0] w);
        vc_mem[vc_wr[5:0]] = w;
        vc_wr = vc_wr + 1;
    endtask

    task automatic init_thr(input logic [3:0] a, input logic [3:0] b);
        umb0 = a;
        umb1 = b;
        init = 1'b1;
        step();
        init = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        init  = 1'b0;
        umb0  = 4'd0;
        umb1  = 4'd0;
        d0_rd = 1'b0;
        d1_rd = 1'b0;
        #1;
        n_checks++;
        if ({vc_rd_enable, d0_wr_enable, d1_wr_enable} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_strobes: got %b want 000",
                     {vc_rd_enable, d0_wr_enable, d1_wr_enable});
        end
        n_checks++;
        if (d_data_out !== 6'h00) begin
            n_errors++;
            $display("FAIL reset_data: got %h want 00", d_data_out);
        end
        n_checks++;
        if ({idle_out, error_out} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_flags: got %b want 00", {idle_out, error_out});
        end
        step();
        step();
        reset = 1'b0;
        push(6'h01);
        push(6'h11);
        push(6'h02);
        run(3);
        n_checks++;
        if (pop_cnt !== 0) begin
            n_errors++;
            $display("FAIL reset_no_pop: got %0d pops want 0", pop_cnt);
        end
        n_checks++;
        if (idle_out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state_idle: got %b want 0", idle_out);
        end
    endtask

    task automatic test_basic();
        bit   [6:0] e_pop;
        bit   [6:0] e_d0;
        bit   [6:0] e_d1;
        bit   [6:0] e_idle;
        logic [5:0] e_dat [7];
        e_pop  = 7'b0000111;
        e_d0   = 7'b0010100;
        e_d1   = 7'b0001000;
        e_idle = 7'b1000001;
        e_dat  = '{6'h00, 6'h00, 6'h01, 6'h11, 6'h02, 6'h00, 6'h00};
        umb0 = 4'd4;
        umb1 = 4'd4;
        init = 1'b1;
        step();
        init = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({vc_rd_enable, idle_out} !== 2'b00) begin
            n_errors++;
            $display("FAIL basic_init_state: got %b want 00", {vc_rd_enable, idle_out});
        end
        step();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_checks++;
            if (vc_rd_enable !== e_pop[i]) begin
                n_errors++;
                $display("FAIL basic_pop[%0d]: got %b want %b", i, vc_rd_enable, e_pop[i]);
            end
            n_checks++;
            if ({d0_wr_enable, d1_wr_enable} !== {e_d0[i], e_d1[i]}) begin
                n_errors++;
                $display("FAIL basic_wr[%0d]: got %b want %b", i,
                         {d0_wr_enable, d1_wr_enable}, {e_d0[i], e_d1[i]});
            end
            n_checks++;
            if (d_data_out !== e_dat[i]) begin
                n_errors++;
                $display("FAIL basic_data[%0d]: got %h want %h", i, d_data_out, e_dat[i]);
            end
            n_checks++;
            if (idle_out !== e_idle[i]) begin
                n_errors++;
                $display("FAIL basic_idle[%0d]: got %b want %b", i, idle_out, e_idle[i]);
            end
            step();
        end
    endtask

    // occ_D0=2 and occ_D1=1 are returned exactly; a miscount would raise error_out.
    task automatic test_drain();
        d0_rd = 1'b1;
        run(2);
        d0_rd = 1'b0;
        d1_rd = 1'b1;
        step();
        d1_rd = 1'b0;
        run(2);
        @(negedge clk);
        n_checks++;
        if ({error_out, idle_out} !== 2'b01) begin
            n_errors++;
            $display("FAIL drain_flags: got %b want 01", {error_out, idle_out});
        end
        step();
    endtask

    task automatic test_thr_d1();
        int base;
        int b1;
        push(6'h10);
        push(6'h13);
        push(6'h15);
        push(6'h1F);
        init_thr(4'd4, 4'd2);
        base = pop_cnt;
        b1   = log1.size();
        run(8);
        n_checks++;
        if (pop_cnt - base !== 2) begin
            n_errors++;
            $display("FAIL thr_d1_block: got %0d pops want 2", pop_cnt - base);
        end
        n_checks++;
        if ({log1[b1], log1[b1+1]} !== {6'h10, 6'h13}) begin
            n_errors++;
            $display("FAIL thr_d1_words: got %h %h want 10 13", log1[b1], log1[b1+1]);
        end
        d1_rd = 1'b1;
        step();
        d1_rd = 1'b0;
        run(6);
        n_checks++;
        if (pop_cnt - base !== 3) begin
            n_errors++;
            $display("FAIL thr_d1_credit1: got %0d pops want 3", pop_cnt - base);
        end
        d1_rd = 1'b1;
        step();
        d1_rd = 1'b0;
        run(6);
        n_checks++;
        if (pop_cnt - base !== 4 || log1.size() - b1 !== 4) begin
            n_errors++;
            $display("FAIL thr_d1_credit2: got %0d pops %0d writes want 4 4",
                     pop_cnt - base, log1.size() - b1);
        end
        n_checks++;
        if (log1[b1+3] !== 6'h1F) begin
            n_errors++;
            $display("FAIL thr_d1_last: got %h want 1f", log1[b1+3]);
        end
        d1_rd = 1'b1;
        run(2);
        d1_rd = 1'b0;
        run(2);
        n_checks++;
        if (error_out !== 1'b0) begin
            n_errors++;
            $display("FAIL thr_d1_drain_err: got %b want 0", error_out);
        end
    endtask

    task automatic test_clamp();
        int base;
        push(6'h01);
        push(6'h02);
        push(6'h03);
        init_thr(4'd0, 4'd9);
        base = pop_cnt;
        run(8);
        n_checks++;
        if (pop_cnt - base !== 1) begin
            n_errors++;
            $display("FAIL clamp_low_block: got %0d pops want 1", pop_cnt - base);
        end
        for (int k = 0; k < 2; k++) begin
            d0_rd = 1'b1;
            step();
            d0_rd = 1'b0;
            run(6);
            n_checks++;
            if (pop_cnt - base !== k + 2) begin
                n_errors++;
                $display("FAIL clamp_low_credit[%0d]: got %0d pops want %0d", k,
                         pop_cnt - base, k + 2);
            end
        end
        n_checks++;
        if (log0[log0.size()-1] !== 6'h03) begin
            n_errors++;
            $display("FAIL clamp_low_last: got %h want 03", log0[log0.size()-1]);
        end
        d0_rd = 1'b1;
        step();
        d0_rd = 1'b0;
        for (int k = 0; k < 5; k++) push(6'h10 + 6'(k));
        base = pop_cnt;
        run(20);
        n_checks++;
        if (pop_cnt - base !== 4) begin
            n_errors++;
            $display("FAIL clamp_high_block: got %0d pops want 4", pop_cnt - base);
        end
        d1_rd = 1'b1;
        run(5);
        d1_rd = 1'b0;
        run(4);
        n_checks++;
        if (pop_cnt - base !== 5 || vc_empty !== 1'b1 || error_out !== 1'b0) begin
            n_errors++;
            $display("FAIL clamp_high_drain: got pops=%0d empty=%b err=%b want 5 1 0",
                     pop_cnt - base, vc_empty, error_out);
        end
    endtask

    task automatic test_init_pending();
        int base;
        init_thr(4'd4, 4'd4);
        push(6'h05);
        push(6'h06);
        push(6'h07);
        push(6'h08);
        @(negedge clk);
        n_checks++;
        if (vc_rd_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL initp_pop0: got %b want 1", vc_rd_enable);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (vc_rd_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL initp_pop1: got %b want 1", vc_rd_enable);
        end
        step();
        init = 1'b1;
        umb0 = 4'd2;
        umb1 = 4'd3;
        @(negedge clk);
        n_checks++;
        if ({vc_rd_enable, d0_wr_enable, d_data_out} !== {2'b01, 6'h05}) begin
            n_errors++;
            $display("FAIL initp_wr0: got rd=%b wr=%b data=%h want 0 1 05",
                     vc_rd_enable, d0_wr_enable, d_data_out);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({vc_rd_enable, d0_wr_enable, d_data_out} !== {2'b01, 6'h06}) begin
            n_errors++;
            $display("FAIL initp_wr1: got rd=%b wr=%b data=%h want 0 1 06",
                     vc_rd_enable, d0_wr_enable, d_data_out);
        end
        step();
        init = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({vc_rd_enable, d0_wr_enable} !== 2'b00) begin
            n_errors++;
            $display("FAIL initp_quiet: got %b want 00", {vc_rd_enable, d0_wr_enable});
        end
        step();
        base = pop_cnt;
        run(6);
        n_checks++;
        if (pop_cnt - base !== 0) begin
            n_errors++;
            $display("FAIL initp_newthr: got %0d pops want 0", pop_cnt - base);
        end
        d0_rd = 1'b1;
        step();
        d0_rd = 1'b0;
        run(6);
        n_checks++;
        if (pop_cnt - base !== 1 || log0[log0.size()-1] !== 6'h07) begin
            n_errors++;
            $display("FAIL initp_credit: got %0d pops last=%h want 1 07",
                     pop_cnt - base, log0[log0.size()-1]);
        end
        d0_rd = 1'b1;
        run(2);
        d0_rd = 1'b0;
        run(5);
        d0_rd = 1'b1;
        step();
        d0_rd = 1'b0;
        run(2);
        n_checks++;
        if (pop_cnt - base !== 2 || error_out !== 1'b0 || vc_empty !== 1'b1) begin
            n_errors++;
            $display("FAIL initp_cleanup: got pops=%0d err=%b empty=%b want 2 0 1",
                     pop_cnt - base, error_out, vc_empty);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int b1;
        push(6'h03);
        run(5);
        push(6'h11);
        @(negedge clk);
        n_checks++;
        if (vc_rd_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_pop: got %b want 1", vc_rd_enable);
        end
        step();
        b1 = log1.size();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({vc_rd_enable, d0_wr_enable, d1_wr_enable, d_data_out, idle_out, error_out}
            !== 11'd0) begin
            n_errors++;
            $display("FAIL rstmid_outputs: got rd=%b w0=%b w1=%b d=%h idle=%b err=%b want 0",
                     vc_rd_enable, d0_wr_enable, d1_wr_enable, d_data_out, idle_out,
                     error_out);
        end
        run(2);
        reset = 1'b0;
        n_checks++;
        if (log1.size() !== b1) begin
            n_errors++;
            $display("FAIL rstmid_no_write: got %0d writes want 0", log1.size() - b1);
        end
        push(6'h04);
        base = pop_cnt;
        run(3);
        n_checks++;
        if (pop_cnt - base !== 0 || idle_out !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_state: got pops=%0d idle=%b want 0 0", pop_cnt - base, idle_out);
        end
        vc_wr = vc_rd;
    endtask

    // occ_D0 was 1 before the reset above; it must be cleared so this pop underflows.
    task automatic test_underflow();
        int base;
        init_thr(4'd4, 4'd4);
        d0_rd = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({idle_out, error_out} !== 2'b10) begin
            n_errors++;
            $display("FAIL uflow_same_cycle: got %b want 10", {idle_out, error_out});
        end
        step();
        d0_rd = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({idle_out, error_out} !== 2'b01) begin
            n_errors++;
            $display("FAIL uflow_flag: got %b want 01", {idle_out, error_out});
        end
        step();
        push(6'h01);
        base = pop_cnt;
        run(4);
        init_thr(4'd4, 4'd4);
        run(3);
        n_checks++;
        if (pop_cnt - base !== 0 || error_out !== 1'b1) begin
            n_errors++;
            $display("FAIL uflow_sticky: got pops=%0d err=%b want 0 1", pop_cnt - base, error_out);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (error_out !== 1'b0) begin
            n_errors++;
            $display("FAIL uflow_clear: got %b want 0", error_out);
        end
        vc_wr = vc_rd;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_drain();
        test_thr_d1();
        test_clamp();
        test_init_pending();
        test_reset_mid();
        test_underflow();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
